l2_data_array_arbiter: RTL and testbench
========================================

// Module: l2_data_array_arbiter
// PURPOSE
//   Arbitrates one single-port L2 data SRAM bank (1 RW port, 1-cycle read latency) between two requesters:
//   a write requester (refill / release data) and a read requester (hit / writeback data).
//   Sits between the L2 banked-store logic and the data array macro.
//   Drives the macro's en/wmode/addr/wmask/wdata and returns tagged read responses.
//   Writes have priority, but a streak limit bounds read starvation.
// PARAMETERS
//   ADDR_BITS      14    SRAM row address width
//   DATA_BITS      1024  row width
//   MASK_BITS      16    write-mask granules (DATA_BITS/MASK_BITS bits each)
//   ID_BITS        4     read tag width, returned unchanged with the response
//   MAX_WR_STREAK  4     max consecutive write grants while a read waits (>=1)
// PORTS
//   clock       in   1          sole clock
//   reset       in   1          synchronous, active-high
//   wr_valid    in   1          write request valid
//   wr_ready    out  1          write granted this cycle
//   wr_addr     in   ADDR_BITS  write row
//   wr_mask     in   MASK_BITS  per-granule write enable
//   wr_data     in   DATA_BITS  write data
//   rd_valid    in   1          read request valid
//   rd_ready    out  1          read granted this cycle
//   rd_addr     in   ADDR_BITS  read row
//   rd_id       in   ID_BITS    read tag
//   rsp_valid   out  1          read data valid (no backpressure)
//   rsp_id      out  ID_BITS    tag of returned read
//   rsp_data    out  DATA_BITS  read data
//   sram_en     out  1          macro enable
//   sram_wmode  out  1          1=write, 0=read
//   sram_addr   out  ADDR_BITS  macro address
//   sram_wmask  out  MASK_BITS  macro write mask
//   sram_wdata  out  DATA_BITS  macro write data
//   sram_rdata  in   DATA_BITS  macro read data (valid the cycle after a read enable)
// BEHAVIOUR
//   Grant (combinational, same cycle):
//   - reset=1: wr_ready=rd_ready=sram_en=0.
//   - If only one request is valid, grant it.
//   - Both valid: grant the write unless streak==MAX_WR_STREAK; in that case grant the read.
//   - At most one grant per cycle.
//   - wr_ready/rd_ready never depend on the other port's ready.
//   SRAM drive:
//   - sram_en = wr_ready|rd_ready; sram_wmode = wr_ready.
//   - sram_addr = granted addr.
//   - sram_wmask = wr_ready ? wr_mask : 0.
//   - sram_wdata = wr_data (don't-care on reads).
//   - A write with wr_mask==0 is still granted and consumes the cycle.
//   Streak counter (clog2(MAX_WR_STREAK+1) bits):
//   - Reset value 0.
//   - +1 on a write grant while rd_valid=1.
//   - Cleared on any read grant, or in any cycle with rd_valid=0.
//   - Saturates at MAX_WR_STREAK; never wraps.
//   Response pipeline (registered):
//   - rsp_valid <= rd_ready and rsp_id <= rd_id on each clock.
//   - rsp_data = sram_rdata (combinational), valid only when rsp_valid=1.
//   - Latency: exactly 1 cycle from read grant to rsp_valid.
//   - Back-to-back reads produce back-to-back responses.
//   - A write granted the cycle after a read does not corrupt that read's response.
//   Reset values: rsp_valid=0, rsp_id=0, streak=0.
//   Reset mid-operation: a read granted the cycle before reset rises has rsp_valid forced 0.
//   No state survives reset.
//   Same-address write then read (consecutive cycles): the read returns the newly written data.
// TESTING
//   1 Reset: hold reset 3 cycles with both valids=1 -> all readies, sram_en, rsp_valid = 0.
//   2 Single read: rd_addr=0x12, rd_id=5 -> rd_ready same cycle; next cycle rsp_valid=1, rsp_id=5,
//     rsp_data=row 0x12.
//   3 Starvation: wr_valid and rd_valid held 1, MAX_WR_STREAK=4 -> grants W,W,W,W,R,W,W,W,W,R...
//   4 Masked write: write row 0x3FFF with mask 0x0001, data all-ones over prior zeros,
//     then read row 0x3FFF -> bits[63:0]=all-ones, rest 0.
//   5 Back-to-back reads with ids 1,2,3 -> rsp_valid 3 consecutive cycles, ids 1,2,3 in order.
//   6 Read granted, then reset asserted the next cycle -> rsp_valid stays 0; streak=0 afterwards.

Source files
------------

// File: rtl/l2_data_array_arbiter.sv
// Arbiter for one single-port L2 data SRAM bank shared by a write requester and a read requester.
// Writes win ties until a streak limit is hit, then the waiting read is granted.
module l2_data_array_arbiter #(
  parameter int ADDR_BITS     = 14,
  parameter int DATA_BITS     = 1024,
  parameter int MASK_BITS     = 16,
  parameter int ID_BITS       = 4,
  parameter int MAX_WR_STREAK = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [MASK_BITS-1:0] wr_mask,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic [ID_BITS-1:0]   rd_id,
  output logic                 rsp_valid,
  output logic [ID_BITS-1:0]   rsp_id,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 sram_en,
  output logic                 sram_wmode,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [MASK_BITS-1:0] sram_wmask,
  output logic [DATA_BITS-1:0] sram_wdata,
  input  logic [DATA_BITS-1:0] sram_rdata
);

  localparam int SW = $clog2(MAX_WR_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_WR_STREAK);

  logic [SW-1:0] streak;
  logic          at_limit;
  logic          rsp_valid_q;

  // Grant decision: write priority unless the read has waited out the streak limit
  always_comb begin
    at_limit = (streak == STREAK_MAX);
    wr_ready = 1'b0;
    rd_ready = 1'b0;
    if (reset) begin
      wr_ready = 1'b0;
      rd_ready = 1'b0;
    end else begin
      wr_ready = wr_valid && !(rd_valid && at_limit);
      rd_ready = rd_valid && (!wr_valid || at_limit);
    end
  end

  // Macro drive follows the granted requester
  always_comb begin
    sram_en    = wr_ready | rd_ready;
    sram_wmode = wr_ready;
    sram_wdata = wr_data;
    if (wr_ready) begin
      sram_addr  = wr_addr;
      sram_wmask = wr_mask;
    end else begin
      sram_addr  = rd_addr;
      sram_wmask = {MASK_BITS{1'b0}};
    end
  end

  // Consecutive write grants while a read waits; saturating
  always_ff @(posedge clock) begin
    if (reset) begin
      streak <= {SW{1'b0}};
    end else if (rd_ready || !rd_valid) begin
      streak <= {SW{1'b0}};
    end else if (wr_ready && !at_limit) begin
      streak <= streak + SW'(1);
    end else begin
      streak <= streak;
    end
  end

  // One-cycle response pipeline matching the macro read latency
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_id      <= {ID_BITS{1'b0}};
    end else begin
      rsp_valid_q <= rd_ready;
      rsp_id      <= rd_id;
    end
  end

  // Reset kills a response already in flight from the previous cycle's read
  assign rsp_valid = rsp_valid_q & ~reset;
  assign rsp_data  = sram_rdata;

endmodule

// File: tb/tb_l2_data_array_arbiter.sv
// Scoreboard bench for l2_data_array_arbiter with a behavioural single-port SRAM model.
module tb_l2_data_array_arbiter;

  localparam int AB = 14;
  localparam int DB = 1024;
  localparam int MB = 16;
  localparam int IB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AB-1:0] wr_addr, rd_addr, sram_addr;
  logic [MB-1:0] wr_mask, sram_wmask;
  logic [DB-1:0] wr_data, rsp_data, sram_wdata, sram_rdata;
  logic [IB-1:0] rd_id, rsp_id;
  logic          rsp_valid, sram_en, sram_wmode;

  l2_data_array_arbiter dut (
    .clock(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_id(rd_id),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM macro model: 1 RW port, read data registered one cycle after enable
  logic [DB-1:0] mem [0:(1<<AB)-1];
  logic [DB-1:0] rdata_q;
  assign sram_rdata = rdata_q;

  function automatic logic [DB-1:0] merge(input logic [DB-1:0] old, input logic [DB-1:0] d,
                                          input logic [MB-1:0] m);
    logic [DB-1:0] r;
    r = old;
    for (int g = 0; g < MB; g++)
      if (m[g]) r[g*(DB/MB) +: (DB/MB)] = d[g*(DB/MB) +: (DB/MB)];
    return r;
  endfunction

  always @(posedge clk) begin
    if (sram_en && sram_wmode) mem[sram_addr] <= merge(mem[sram_addr], sram_wdata, sram_wmask);
    else if (sram_en) rdata_q <= mem[sram_addr];
  end

  typedef struct {
    logic          w;
    logic          r;
    logic [AB-1:0] addr;
    logic [MB-1:0] mask;
    logic [DB-1:0] wd;
    int            quiet;
  } grant_t;

  typedef struct {
    int            cyc;
    logic [IB-1:0] id;
    logic [DB-1:0] data;
  } rsp_t;

  grant_t gq[$];
  rsp_t   rq[$];
  int     cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  logic [DB-1:0] pat, npat, low64;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: checks each cycle's grant expectation and every presented response
  initial forever begin
    grant_t g;
    rsp_t   e;
    @(negedge clk);
    if (gq.size() != 0) begin
      g = gq.pop_front();
      n_checks++;
      if (wr_ready !== g.w || rd_ready !== g.r)
        $display("FAIL grant cyc=%0d got w=%b r=%b want w=%b r=%b", cyc, wr_ready, rd_ready, g.w, g.r);
      else n_pass++;
      n_checks++;
      if (sram_en !== (g.w | g.r) || sram_wmode !== g.w || sram_wmask !== g.mask ||
          ((g.w | g.r) && sram_addr !== g.addr) || (g.w && sram_wdata !== g.wd))
        $display("FAIL sram cyc=%0d got en=%b wm=%b addr=%h mask=%h want en=%b wm=%b addr=%h mask=%h",
                 cyc, sram_en, sram_wmode, sram_addr, sram_wmask, g.w | g.r, g.w, g.addr, g.mask);
      else n_pass++;
      if (g.quiet >= 1) begin
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL rsp_quiet cyc=%0d got rsp_valid=%b want 0", cyc, rsp_valid);
        else n_pass++;
      end
      if (g.quiet >= 2) begin
        n_checks++;
        if (rsp_id !== 4'h0) $display("FAIL rsp_id_reset cyc=%0d got %h want 0", cyc, rsp_id);
        else n_pass++;
      end
    end
    if (rsp_valid === 1'b1) begin
      n_checks++;
      if (rq.size() == 0) begin
        $display("FAIL rsp_unexpected cyc=%0d got id=%h want no response", cyc, rsp_id);
      end else begin
        e = rq.pop_front();
        if (rsp_id !== e.id || rsp_data !== e.data || cyc != e.cyc)
          $display("FAIL rsp cyc=%0d got id=%h data[127:0]=%h want cyc=%0d id=%h data[127:0]=%h",
                   cyc, rsp_id, rsp_data[127:0], e.cyc, e.id, e.data[127:0]);
        else n_pass++;
      end
    end
  end

  task automatic drive(input logic rs, input logic wv, input logic [AB-1:0] wa, input logic [MB-1:0] wm,
                       input logic [DB-1:0] wd, input logic rv, input logic [AB-1:0] ra,
                       input logic [IB-1:0] id);
    @(posedge clk);
    #1;
    reset = rs; wr_valid = wv; wr_addr = wa; wr_mask = wm; wr_data = wd;
    rd_valid = rv; rd_addr = ra; rd_id = id;
  endtask

  task automatic expect_grant(input logic ew, input logic er, input int quiet);
    grant_t g;
    g.w = ew; g.r = er;
    g.addr = ew ? wr_addr : rd_addr;
    g.mask = ew ? wr_mask : 16'h0000;
    g.wd = wr_data;
    g.quiet = quiet;
    gq.push_back(g);
  endtask

  task automatic expect_rsp(input logic [IB-1:0] id, input logic [DB-1:0] d);
    rsp_t e;
    e.cyc = cyc + 1; e.id = id; e.data = d;
    rq.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 14'h0, 16'h0, npat, 1'b0, 14'h0, 4'h0);
    expect_grant(1'b0, 1'b0, 0);
  endtask

  task automatic wr(input logic [AB-1:0] a, input logic [MB-1:0] m, input logic [DB-1:0] d);
    drive(1'b0, 1'b1, a, m, d, 1'b0, 14'h0, 4'h0);
    expect_grant(1'b1, 1'b0, 0);
  endtask

  task automatic rd(input logic [AB-1:0] a, input logic [IB-1:0] id, input logic [DB-1:0] ed);
    drive(1'b0, 1'b0, 14'h0, 16'h0, npat, 1'b1, a, id);
    expect_grant(1'b0, 1'b1, 0);
    expect_rsp(id, ed);
  endtask

  // Both requesters valid; write targets row 0x200, read targets row 0x12 (holds pat)
  task automatic both(input logic [IB-1:0] id, input logic ew);
    drive(1'b0, 1'b1, 14'h0200, 16'hFFFF, npat, 1'b1, 14'h0012, id);
    expect_grant(ew, !ew, 0);
    if (!ew) expect_rsp(id, pat);
  endtask

  task automatic rst_cycle(input int quiet);
    drive(1'b1, 1'b1, 14'h0200, 16'hFFFF, npat, 1'b1, 14'h0012, 4'hF);
    expect_grant(1'b0, 1'b0, quiet);
  endtask

  initial begin
    for (int i = 0; i < (1 << AB); i++) mem[i] = '0;
    rdata_q = '0;
    for (int i = 0; i < 32; i++) pat[i*32 +: 32] = 32'hA5C30000 ^ i;
    npat = ~pat;
    low64 = '0;
    low64[63:0] = {64{1'b1}};
    reset = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; wr_addr = '0; rd_addr = '0;
    wr_mask = '0; wr_data = '0; rd_id = '0;

    // Reset held with both valids
    rst_cycle(1);
    rst_cycle(2);
    rst_cycle(2);
    idle();

    // Single read of a known row, then a zero-mask write that must not alter it
    wr(14'h0012, 16'hFFFF, pat);
    rd(14'h0012, 4'h5, pat);
    idle();
    wr(14'h0012, 16'h0000, npat);
    rd(14'h0012, 4'h6, pat);

    // Masked write then same-row read, followed by a write while the response returns
    wr(14'h3FFF, 16'h0001, {DB{1'b1}});
    rd(14'h3FFF, 4'h7, low64);
    wr(14'h0100, 16'hFFFF, pat);
    idle();

    // Back-to-back reads
    rd(14'h0012, 4'h1, pat);
    rd(14'h3FFF, 4'h2, low64);
    rd(14'h0100, 4'h3, pat);
    idle();

    // Starvation bound: W,W,W,W,R repeating
    for (int i = 0; i < 10; i++) both(4'(8 + i), (i % 5) != 4);
    idle();

    // Streak built up then reset: pattern restarts from zero
    for (int i = 0; i < 3; i++) both(4'h4, 1'b1);
    rst_cycle(1);
    for (int i = 0; i < 5; i++) both(4'hA, i != 4);
    idle();

    // Read granted, reset the next cycle: its response is suppressed
    drive(1'b0, 1'b0, 14'h0, 16'h0, npat, 1'b1, 14'h0012, 4'h9);
    expect_grant(1'b0, 1'b1, 0);
    rst_cycle(1);
    for (int i = 0; i < 5; i++) both(4'hC, i != 4);
    idle();
    idle();

    for (int i = 0; i < 20 && (rq.size() != 0 || gq.size() != 0); i++) @(posedge clk);
    n_checks++;
    if (rq.size() != 0 || gq.size() != 0)
      $display("FAIL drain got %0d responses and %0d grants pending want 0", rq.size(), gq.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
